// File: rtl/instr_decode_fsm.sv
// Multi-cycle instruction decoder: latches an instruction word, sequences
// DECODE/EXEC/MEM/WB with stall and memory-timeout handling, and counts retires.
module instr_decode_fsm #(
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned RA_W    = 5,
  parameter logic [OP_W-1:0] MEM_OP = OP_W'(4'hE),
  parameter int unsigned NUM_OPS = 14,
  parameter int unsigned TMO     = 15,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned INSTR_W = IMM_W + OP_W + 2 + 2 * RA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall,
  input  logic               mem_ack,
  output logic [IMM_W-1:0]   imm,
  output logic [OP_W-1:0]    opcode,
  output logic               load_immediate,
  output logic               read_write,
  output logic [RA_W-1:0]    addr1,
  output logic [RA_W-1:0]    addr2,
  output logic               alu_en,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic               reg_wr_en,
  output logic               illegal,
  output logic               mem_err,
  output logic               busy,
  output logic [CNT_W-1:0]   instr_count,
  output logic [2:0]         state_dbg
);

  localparam int unsigned TMR_W = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO - 1);

  // Field positions, LSB upward: addr2, addr1, read_write, load_immediate, opcode, imm.
  localparam int unsigned A1_LSB = RA_W;
  localparam int unsigned RW_BIT = 2 * RA_W;
  localparam int unsigned LI_BIT = 2 * RA_W + 1;
  localparam int unsigned OP_LSB = 2 * RA_W + 2;
  localparam int unsigned IM_LSB = 2 * RA_W + 2 + OP_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic              li_q, li_d;
  logic              rw_q, rw_d;
  logic [RA_W-1:0]   addr1_q, addr1_d;
  logic [RA_W-1:0]   addr2_q, addr2_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              alu_q, alu_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              reg_wr_q, reg_wr_d;
  logic              illegal_q, illegal_d;
  logic              mem_err_q, mem_err_d;
  logic              retire;
  logic              accept;
  logic              op_illegal;

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1; instr must be stable while instr_valid is high, and
  // instr_ready depends only on state, stall and rst_n (never on instr_valid).
  assign instr_ready = rst_n && (state_q == S_IDLE) && !stall;
  assign accept      = instr_valid && instr_ready;
  assign op_illegal  = (32'(opcode_q) >= NUM_OPS) && (opcode_q != MEM_OP);

  always_comb begin
    state_d   = state_q;
    imm_d     = imm_q;
    opcode_d  = opcode_q;
    li_d      = li_q;
    rw_d      = rw_q;
    addr1_d   = addr1_q;
    addr2_d   = addr2_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    mem_err_d = 1'b0;
    retire    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          imm_d    = instr[IM_LSB +: IMM_W];
          opcode_d = instr[OP_LSB +: OP_W];
          li_d     = instr[LI_BIT];
          rw_d     = instr[RW_BIT];
          addr1_d  = instr[A1_LSB +: RA_W];
          addr2_d  = instr[0 +: RA_W];
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!stall) begin
          if (op_illegal) begin
            state_d   = S_IDLE;
            illegal_d = 1'b1;
          end else if (li_q) begin
            state_d = S_WB;
          end else if (opcode_q == MEM_OP) begin
            state_d = S_MEM;
            tmr_d   = '0;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (!stall) state_d = S_WB;
      end
      S_MEM: begin
        // An ack in the last allowed cycle still completes the access.
        if (!stall) begin
          if (mem_ack) begin
            if (rw_q) begin
              state_d = S_WB;
            end else begin
              state_d = S_IDLE;
              retire  = 1'b1;
            end
          end else if (tmr_q == TMR_LAST) begin
            state_d   = S_IDLE;
            mem_err_d = 1'b1;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
      end
      S_WB: begin
        if (!stall) begin
          state_d = S_IDLE;
          retire  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (retire && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);

    // Strobe flops mark the state being entered; stall masks them at the output.
    alu_d    = (state_d == S_EXEC);
    reg_wr_d = (state_d == S_WB);
    mem_rd_d = (state_d == S_MEM) && rw_d;
    mem_wr_d = (state_d == S_MEM) && !rw_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      imm_q     <= '0;
      opcode_q  <= '0;
      li_q      <= 1'b0;
      rw_q      <= 1'b0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      tmr_q     <= '0;
      cnt_q     <= '0;
      alu_q     <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      reg_wr_q  <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      imm_q     <= imm_d;
      opcode_q  <= opcode_d;
      li_q      <= li_d;
      rw_q      <= rw_d;
      addr1_q   <= addr1_d;
      addr2_q   <= addr2_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      alu_q     <= alu_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      reg_wr_q  <= reg_wr_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign imm            = imm_q;
  assign opcode         = opcode_q;
  assign load_immediate = li_q;
  assign read_write     = rw_q;
  assign addr1          = addr1_q;
  assign addr2          = addr2_q;
  assign alu_en         = alu_q & ~stall;
  assign mem_rd_en      = mem_rd_q & ~stall;
  assign mem_wr_en      = mem_wr_q & ~stall;
  assign reg_wr_en      = reg_wr_q & ~stall;
  assign illegal        = illegal_q;
  assign mem_err        = mem_err_q;
  assign busy           = (state_q != S_IDLE);
  assign instr_count    = cnt_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_instr_decode_fsm.sv
// Self-checking bench for instr_decode_fsm: per-cycle strobe scoreboard,
// decoded-field checks, mid-operation reset and counter saturation.
module tb_instr_decode_fsm;

  localparam int IMM_W = 16;
  localparam int OP_W = 4;
  localparam int RA_W = 5;
  localparam int INSTR_W = IMM_W + OP_W + 2 + 2 * RA_W;
  localparam int CNT_W = 16;
  localparam int TMO = 15;

  localparam int K_LI = 0;
  localparam int K_ALU = 1;
  localparam int K_RD = 2;
  localparam int K_WR = 3;
  localparam int K_ILL = 4;

  logic               clk;
  logic               rst_n;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic               stall;
  logic               mem_ack;
  logic [IMM_W-1:0]   imm;
  logic [OP_W-1:0]    opcode;
  logic               load_immediate, read_write;
  logic [RA_W-1:0]    addr1, addr2;
  logic               alu_en, mem_rd_en, mem_wr_en, reg_wr_en;
  logic               illegal, mem_err, busy;
  logic [CNT_W-1:0]   instr_count;
  logic [2:0]         state_dbg;

  logic               s_instr_ready;
  logic [IMM_W-1:0]   s_imm;
  logic [OP_W-1:0]    s_opcode;
  logic               s_li, s_rw;
  logic [RA_W-1:0]    s_addr1, s_addr2;
  logic               s_alu_en, s_mem_rd_en, s_mem_wr_en, s_reg_wr_en;
  logic               s_illegal, s_mem_err, s_busy;
  logic [1:0]         s_instr_count;
  logic [2:0]         s_state_dbg;

  instr_decode_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .stall(stall), .mem_ack(mem_ack), .imm(imm), .opcode(opcode),
    .load_immediate(load_immediate), .read_write(read_write), .addr1(addr1), .addr2(addr2),
    .alu_en(alu_en), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .reg_wr_en(reg_wr_en),
    .illegal(illegal), .mem_err(mem_err), .busy(busy), .instr_count(instr_count),
    .state_dbg(state_dbg)
  );

  instr_decode_fsm #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(s_instr_ready),
    .instr(instr), .stall(stall), .mem_ack(mem_ack), .imm(s_imm), .opcode(s_opcode),
    .load_immediate(s_li), .read_write(s_rw), .addr1(s_addr1), .addr2(s_addr2),
    .alu_en(s_alu_en), .mem_rd_en(s_mem_rd_en), .mem_wr_en(s_mem_wr_en), .reg_wr_en(s_reg_wr_en),
    .illegal(s_illegal), .mem_err(s_mem_err), .busy(s_busy), .instr_count(s_instr_count),
    .state_dbg(s_state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;
  logic [7:0] exp_q[$];
  logic [2:0] stim_q[$];

  function automatic logic [7:0] vec(input logic rdy, input logic bsy, input logic alu,
                                     input logic rd, input logic wr, input logic rg,
                                     input logic ill, input logic err);
    return {rdy, bsy, alu, rd, wr, rg, ill, err};
  endfunction

  function automatic logic [7:0] act_vec();
    return {instr_ready, busy, alu_en, mem_rd_en, mem_wr_en, reg_wr_en, illegal, mem_err};
  endfunction

  function automatic logic [INSTR_W-1:0] mk(input logic [15:0] im, input logic [3:0] op,
                                            input logic li, input logic rw,
                                            input logic [4:0] a1, input logic [4:0] a2);
    return {im, op, li, rw, a1, a2};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic v, input logic st, input logic ack, input logic [7:0] e);
    stim_q.push_back({v, st, ack});
    exp_q.push_back(e);
  endtask

  // Builds the stimulus and the expected per-cycle outputs of one instruction.
  // w = MEM cycles without ack before the ack cycle (-1: never ack),
  // s = stalled cycles right after DECODE, pre = stalled idle cycles before accept.
  task automatic add_txn(input int kind, input int w, input int s, input int pre);
    logic rd;
    logic err;
    err = 1'b0;
    rd = (kind == K_RD);
    for (int i = 0; i < pre; i++) push(1'b1, 1'b1, 1'b0, vec(0, 0, 0, 0, 0, 0, 0, 0));
    push(1'b1, 1'b0, 1'($urandom_range(0, 1)), vec(1, 0, 0, 0, 0, 0, 0, 0));
    push(1'b0, 1'b0, 1'($urandom_range(0, 1)), vec(0, 1, 0, 0, 0, 0, 0, 0));
    if (kind == K_ILL) begin
      push(1'b0, 1'b0, 1'b0, vec(1, 0, 0, 0, 0, 0, 1, 0));
    end else begin
      for (int i = 0; i < s; i++) push(1'b0, 1'b1, 1'b1, vec(0, 1, 0, 0, 0, 0, 0, 0));
      case (kind)
        K_LI: begin
          push(1'b0, 1'b0, 1'b0, vec(0, 1, 0, 0, 0, 1, 0, 0));
          exp_cnt++;
        end
        K_ALU: begin
          push(1'b0, 1'b0, 1'b0, vec(0, 1, 1, 0, 0, 0, 0, 0));
          push(1'b0, 1'b0, 1'b0, vec(0, 1, 0, 0, 0, 1, 0, 0));
          exp_cnt++;
        end
        default: begin
          if (w < 0) begin
            for (int i = 0; i < TMO; i++) push(1'b0, 1'b0, 1'b0, vec(0, 1, 0, rd, !rd, 0, 0, 0));
            err = 1'b1;
          end else begin
            for (int i = 0; i < w; i++) push(1'b0, 1'b0, 1'b0, vec(0, 1, 0, rd, !rd, 0, 0, 0));
            push(1'b0, 1'b0, 1'b1, vec(0, 1, 0, rd, !rd, 0, 0, 0));
            if (rd) push(1'b0, 1'b0, 1'b0, vec(0, 1, 0, 0, 0, 1, 0, 0));
            exp_cnt++;
          end
        end
      endcase
      push(1'b0, 1'b0, 1'b0, vec(1, 0, 0, 0, 0, 0, 0, err));
    end
  endtask

  task automatic drain();
    logic [2:0] st;
    logic [7:0] e;
    while (stim_q.size() > 0) begin
      st = stim_q.pop_front();
      @(posedge clk);
      #1;
      {instr_valid, stall, mem_ack} = st;
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq("cycle", 32'(act_vec()), 32'(e));
    end
    @(posedge clk);
    #1;
    {instr_valid, stall, mem_ack} = 3'b000;
  endtask

  task automatic run_txn(input logic [INSTR_W-1:0] iw, input int kind, input int w,
                         input int s, input int pre);
    instr = iw;
    add_txn(kind, w, s, pre);
    drain();
    @(negedge clk);
    check_eq("count", 32'(instr_count), 32'(exp_cnt));
    check_eq("sat_count", 32'(s_instr_count), (exp_cnt > 3) ? 32'd3 : 32'(exp_cnt));
    check_eq("fields", {imm, opcode, load_immediate, read_write, addr1, addr2}, iw);
  endtask

  initial begin
    int kind;
    logic [3:0] op;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    stall = 1'b0;
    mem_ack = 1'b0;
    instr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_vec", 32'(act_vec()), 32'd0);
    check_eq("reset_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", 32'(act_vec()), 32'(vec(1, 0, 0, 0, 0, 0, 0, 0)));

    run_txn(mk(16'hBEEF, 4'h3, 1'b1, 1'b0, 5'd7, 5'd2), K_LI, 0, 0, 0);
    run_txn(mk(16'h1234, 4'hE, 1'b0, 1'b1, 5'd3, 5'd9), K_RD, 2, 0, 0);
    run_txn(mk(16'h0F0F, 4'hE, 1'b0, 1'b0, 5'd1, 5'd4), K_WR, -1, 0, 0);
    run_txn(mk(16'hDEAD, 4'hF, 1'b0, 1'b0, 5'd5, 5'd6), K_ILL, 0, 0, 0);
    run_txn(mk(16'h0042, 4'h2, 1'b0, 1'b0, 5'd8, 5'd1), K_ALU, 0, 4, 0);
    run_txn(mk(16'h00AA, 4'hE, 1'b0, 1'b0, 5'd2, 5'd2), K_WR, 0, 0, 0);
    run_txn(mk(16'h5555, 4'hE, 1'b0, 1'b1, 5'd31, 5'd0), K_RD, 1, 2, 0);
    run_txn(mk(16'h7777, 4'h0, 1'b1, 1'b1, 5'd0, 5'd31), K_LI, 0, 0, 2);
    run_txn(mk(16'h0D0D, 4'hD, 1'b0, 1'b1, 5'd12, 5'd13), K_ALU, 0, 0, 0);
    run_txn(mk(16'h0E0E, 4'hE, 1'b1, 1'b0, 5'd14, 5'd15), K_LI, 0, 0, 0);
    run_txn(mk(16'hF1F1, 4'hF, 1'b1, 1'b1, 5'd16, 5'd17), K_ILL, 0, 0, 0);
    run_txn(mk(16'h3C3C, 4'hE, 1'b0, 1'b1, 5'd18, 5'd19), K_RD, -1, 1, 0);
    run_txn(mk(16'hC3C3, 4'hE, 1'b0, 1'b0, 5'd20, 5'd21), K_WR, TMO - 1, 0, 0);
    run_txn(mk(16'h6666, 4'hE, 1'b0, 1'b1, 5'd22, 5'd23), K_RD, 0, 3, 0);

    for (int n = 0; n < 8; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        K_ALU: op = 4'($urandom_range(0, 13));
        K_ILL: op = 4'hF;
        K_LI:  op = 4'($urandom_range(0, 15));
        default: op = 4'hE;
      endcase
      run_txn(mk(16'($urandom), op, kind == K_LI, kind == K_RD,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))),
              kind, $urandom_range(0, 4), (kind == K_ILL) ? 0 : $urandom_range(0, 3),
              $urandom_range(0, 1));
    end

    // Reset in the middle of a memory read that is never acknowledged.
    instr = mk(16'hABCD, 4'hE, 1'b0, 1'b1, 5'd9, 5'd10);
    @(posedge clk);
    #1 instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("mem_rd_before_reset", 32'(act_vec()), 32'(vec(0, 1, 0, 1, 0, 0, 0, 0)));
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("pre_reset_edge", 32'(mem_rd_en), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("mid_reset_vec", 32'(act_vec()), 32'd0);
    check_eq("mid_reset_fields", {imm, opcode, load_immediate, read_write, addr1, addr2}, 32'd0);
    check_eq("mid_reset_count", 32'(instr_count), 32'd0);
    exp_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_mid_reset", 32'(act_vec()), 32'(vec(1, 0, 0, 0, 0, 0, 0, 0)));

    for (int n = 0; n < 5; n++)
      run_txn(mk(16'(n), 4'h1, 1'b1, 1'b0, 5'(n), 5'd0), K_LI, 0, 0, 0);
    check_eq("sat_final", 32'(s_instr_count), 32'd3);
    check_eq("wide_final", 32'(instr_count), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_decode_fsm.md
INSTR_DECODE_FSM -- requirements
Module: instr_decode_fsm

Interface
REQ-001 The block SHALL take parameters, one per line: name, default, meaning.
- IMM_W  16  immediate/data field width
- OP_W  4  opcode width
- RA_W  5  register address width
- MEM_OP  4'hE  opcode selecting a memory access
- NUM_OPS  14  opcodes >= NUM_OPS are illegal (MEM_OP is exempt)
- TMO  15  memory-ack timeout in cycles (>=1)
- CNT_W  16  retired-instruction counter width
REQ-002 INSTR_W SHALL be a derived localparam equal to IMM_W+OP_W+2+2*RA_W. Field order MSB->LSB: imm, opcode, load_immediate, read_write, addr1, addr2.
REQ-003 Ports, one per line: name  direction  width  meaning.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept
- instr  in  INSTR_W  instruction word
- stall  in  1  freeze pipeline
- mem_ack  in  1  memory access complete
- imm  out  IMM_W  latched immediate field
- opcode  out  OP_W  latched opcode
- load_immediate  out  1  latched LI bit
- read_write  out  1  latched R/W bit (1=read)
- addr1, addr2  out  RA_W each  latched register addresses
- alu_en, mem_rd_en, mem_wr_en, reg_wr_en  out  1 each  control strobes
- illegal, mem_err  out  1 each  single-cycle error pulses
- busy  out  1  FSM not in IDLE
- instr_count  out  CNT_W  retired instructions
REQ-004 The block SHALL have one clock, clk; reset SHALL be synchronous and active-low, on rst_n.

Function
REQ-005 FSM states SHALL be IDLE, DECODE, EXEC, MEM, WB.
REQ-006 instr_ready SHALL equal (state==IDLE && !stall). An instruction is accepted on an edge where instr_valid && instr_ready; fields latch into the decoded outputs and the FSM enters DECODE.
REQ-007 Decoded outputs SHALL hold stable until the next accept.
REQ-008 DECODE transitions, in this priority:
- opcode>=NUM_OPS && opcode!=MEM_OP -> IDLE, illegal pulsed 1 cycle, no retire.
- load_immediate=1 -> WB.
- opcode==MEM_OP -> MEM.
- else -> EXEC.
REQ-009 EXEC SHALL assert alu_en for one cycle, then go to WB.
REQ-010 MEM SHALL assert mem_rd_en (read_write=1) or mem_wr_en (read_write=0) every cycle until mem_ack, including the entry cycle.
REQ-011 On mem_ack in MEM: reads SHALL go to WB; writes SHALL go to IDLE and retire.
REQ-012 A timeout counter SHALL clear on MEM entry and count MEM cycles without mem_ack. If ack is absent for TMO cycles, the FSM SHALL go to IDLE with mem_err pulsed 1 cycle, no retire. mem_ack on cycle TMO SHALL win over the timeout.
REQ-013 WB SHALL assert reg_wr_en for one cycle, go to IDLE and retire.
REQ-014 Latency from the accept edge to the retire edge: LI 2 cycles, ALU 3, memory read 3+wait, memory write 2+wait.
REQ-015 Retiring SHALL increment instr_count, saturating at 2^CNT_W-1.
REQ-016 While stall=1 in a non-IDLE state, the FSM and timeout counter SHALL hold and all strobes SHALL be 0. Strobes resume on the first unstalled cycle.
REQ-017 mem_ack outside MEM, or while stalled, SHALL be ignored.
REQ-018 busy SHALL equal (state!=IDLE).

Reset
REQ-019 rst_n=0 at any edge, including mid-operation, SHALL force IDLE and zero all outputs, instr_count and the timeout counter. instr_ready SHALL be 1 on the first edge after release if stall=0.

Verification
REQ-020 LI: instr={16'hBEEF,4'h3,1,0,5'd7,5'd2}, valid 1 cycle -> DECODE, WB (reg_wr_en=1, imm=16'hBEEF, addr1=7), IDLE; instr_count=1.
REQ-021 Memory read: opcode=4'hE, read_write=1, mem_ack after 3 MEM cycles -> mem_rd_en high for exactly 3 cycles, then WB with reg_wr_en=1; count+1.
REQ-022 Timeout: opcode=4'hE, read_write=0, no mem_ack -> mem_wr_en high for 15 cycles, mem_err pulses, IDLE, count unchanged.
REQ-023 Illegal: opcode=4'hF -> illegal pulse in the cycle after DECODE, no strobes, count unchanged.
REQ-024 Stall: ALU op with stall high for 4 cycles in EXEC -> alu_en 0 while stalled, exactly one alu_en cycle after release.
REQ-025 Reset and saturation: rst_n low during MEM -> all outputs 0 next edge. CNT_W=2 with 5 retires -> instr_count=3.
